ifetch_queue: RTL and testbench
===============================

// Module: ifetch_queue
// PURPOSE
//  Parametrised next-generation instruction fetch stage. Fetches from the icache at pc,
//  follows jal / predicted-taken branches, stalls on jalr until ALU resolves it, and
//  buffers fetched instructions in a DEPTH-entry FIFO decoupling fetch from issue.
//  Sits between icache/predictor and the decoder/issue logic; redirected by ROB and ALU.
// PARAMETERS
//  DEPTH     4   instruction queue entries; power of 2, >= 2
//  RESET_PC  0   pc value loaded on reset
// PORTS
//  clk            in   1   clock
//  rst            in   1   synchronous active-high reset
//  rdy            in   1   global enable; when 0 all state holds
//  pc_to_icache   out  32  current fetch pc (== pc register)
//  fetch_req      out  1   1 when a fetch is wanted: !stall && count<DEPTH
//  icache_hit     in   1   icache_inst valid for pc_to_icache this cycle
//  icache_inst    in   32  instruction word at pc_to_icache
//  predict_pc     out  32  pc sent to predictor (== pc register)
//  predict_taken  in   1   predictor taken/not-taken for predict_pc
//  issue_valid    out  1   queue head valid (count!=0)
//  issue_ready    in   1   consumer accepts head (caller ANDs !ROB_full,!LSB_full,!RS_full)
//  issue_inst     out  32  head instruction
//  issue_pc       out  32  head pc
//  issue_predict  out  1   head predicted taken (1 only for branch opcode 1100011)
//  jalr_valid     in   1   jalr target resolved
//  jalr_pc        in   32  resolved jalr target
//  rollback       in   1   ROB misprediction; flush and redirect
//  rollback_pc    in   32  correct pc after rollback
//  q_count        out  $clog2(DEPTH)+1  entries currently held
// BEHAVIOUR
//  Reset (rst=1 at posedge, rdy ignored): pc=RESET_PC, stall=0, head=tail=count=0;
//   hence issue_valid=0, fetch_req=1, issue_predict=0, issue_inst/issue_pc=0 (entries cleared).
//  rdy=0: no enqueue, dequeue, pc change or stall change.
//  Enqueue when fetch_req && icache_hit && !rollback && !jalr_valid: write {inst,pc,pred}
//   at tail, tail++ (mod DEPTH). pred = predict_taken && opcode==1100011.
//  Next pc on enqueue: branch&&predict_taken -> pc+immB; jal(1101111) -> pc+immJ;
//   jalr(1100111) -> pc unchanged, stall<=1; else pc+4. All sums mod 2^32.
//   immB={{19{i[31]}},i[31],i[7],i[30:25],i[11:8],1'b0}; immJ={{11{i[31]}},i[31],i[19:12],i[20],i[30:21],1'b0}.
//  Dequeue when issue_valid && issue_ready && !rollback: head++ (mod DEPTH).
//  Enqueue and dequeue in same cycle: count unchanged. Full (count==DEPTH): fetch_req=0,
//   no enqueue even if a dequeue occurs that cycle (one-cycle bubble, no combinational bypass).
//  Fetch latency: instruction hit at cycle N is visible on issue_* at N+1 if queue was empty.
//  jalr_valid (not rollback): pc<=jalr_pc, stall<=0, queue kept, no enqueue that cycle.
//   jalr_valid while stall==0: pc still redirected (ALU is authoritative).
//  rollback: highest priority over everything: pc<=rollback_pc, stall<=0, head=tail=count=0,
//   no enqueue/dequeue that cycle; issue_valid=0 next cycle.
//  rollback && jalr_valid same cycle: rollback wins, jalr_pc discarded.
//  icache miss: pc holds, nothing enqueued, retry next cycle.
//  State: {FETCH (stall=0), JALR_WAIT (stall=1)}; FETCH->JALR_WAIT on jalr enqueue;
//   JALR_WAIT->FETCH on jalr_valid or rollback. In JALR_WAIT fetch_req=0, queue drains normally.
// TESTING
//  1 Reset, RESET_PC=0, hit always, insts addi, issue_ready=0: 4 enqueues pcs 0,4,8,C; count=4,
//    fetch_req=0; then ready=1 -> issue_pc 0,4,8,C on consecutive cycles.
//  2 pc=0x10 beq imm=+0x20, predict_taken=1 -> next pc 0x30, issue_predict=1; with taken=0 -> 0x14, predict=0.
//  3 jal at 0x40 imm=-8 -> next pc 0x38; jalr at 0x38 -> fetch_req=0 until jalr_valid,jalr_pc=0x100
//    -> next fetch pc 0x100, jalr entry still issued.
//  4 Queue holds 3 entries, rollback=1 rollback_pc=0x200 with jalr_valid=1 jalr_pc=0x300 ->
//    count=0, issue_valid=0, pc=0x200, stall=0.
//  5 Full queue, issue_ready=1 and icache_hit=1 same cycle -> count 4->3, no enqueue; next cycle enqueue.
//  6 rdy=0 for 3 cycles mid-stream with hit/ready asserted -> pc, count, head unchanged.

Source files
------------

// File: rtl/ifetch_queue.sv
// ----------------------------------------------------------------------------
// ifetch_queue
//
// Instruction fetch stage with a small decoupling queue. Each cycle it
// presents pc to the icache and the branch predictor. It follows jal and
// predicted-taken conditional branches immediately. It stalls after fetching
// a jalr until the ALU supplies the target. Fetched instructions are buffered
// in a DEPTH-entry circular queue that the decoder/issue logic drains.
//
// Parameters
//   DEPTH     queue entries (power of 2, >= 2)
//   RESET_PC  pc loaded on reset
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   rdy             global enable; all state holds while low
//   pc_to_icache    current fetch pc
//   fetch_req       fetch wanted this cycle (not stalled, queue not full)
//   icache_hit      icache_inst is valid for pc_to_icache
//   icache_inst     instruction word at pc_to_icache
//   predict_pc      pc presented to the predictor
//   predict_taken   predictor decision for predict_pc
//   issue_valid     queue head valid
//   issue_ready     consumer accepts the head this cycle
//   issue_inst      head instruction
//   issue_pc        head pc
//   issue_predict   head was predicted taken (conditional branches only)
//   jalr_valid      resolved jalr target available
//   jalr_pc         resolved jalr target
//   rollback        misprediction flush from the ROB, highest priority
//   rollback_pc     restart pc after rollback
//   q_count         number of entries currently held
// ----------------------------------------------------------------------------
module ifetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       rdy,
    output logic [31:0]                pc_to_icache,
    output logic                       fetch_req,
    input  logic                       icache_hit,
    input  logic [31:0]                icache_inst,
    output logic [31:0]                predict_pc,
    input  logic                       predict_taken,
    output logic                       issue_valid,
    input  logic                       issue_ready,
    output logic [31:0]                issue_inst,
    output logic [31:0]                issue_pc,
    output logic                       issue_predict,
    input  logic                       jalr_valid,
    input  logic [31:0]                jalr_pc,
    input  logic                       rollback,
    input  logic [31:0]                rollback_pc,
    output logic [$clog2(DEPTH):0]     q_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef enum logic {
        FETCH     = 1'b0,
        JALR_WAIT = 1'b1
    } state_t;

    state_t          state_q;
    logic [31:0]     pc_q;
    logic [AW-1:0]   head_q;
    logic [AW-1:0]   tail_q;
    logic [CW-1:0]   count_q;
    logic [CW-1:0]   count_d;
    logic [31:0]     next_pc_d;

    logic [31:0]     inst_mem_q [DEPTH];
    logic [31:0]     pc_mem_q   [DEPTH];
    logic            pred_mem_q [DEPTH];

    // ------------------------------------------------------------------
    // Decode of the word currently returned by the icache
    // ------------------------------------------------------------------
    logic [6:0]  opcode;
    logic        is_branch;
    logic        is_jal;
    logic        is_jalr;
    logic        pred_d;
    logic [31:0] imm_b;
    logic [31:0] imm_j;

    assign opcode    = icache_inst[6:0];
    assign is_branch = (opcode == OP_BRANCH);
    assign is_jal    = (opcode == OP_JAL);
    assign is_jalr   = (opcode == OP_JALR);
    // Prediction is only meaningful for conditional branches; the predictor
    // may say "taken" for any pc, so mask it here.
    assign pred_d    = predict_taken && is_branch;

    assign imm_b = {{19{icache_inst[31]}}, icache_inst[31], icache_inst[7],
                    icache_inst[30:25], icache_inst[11:8], 1'b0};
    assign imm_j = {{11{icache_inst[31]}}, icache_inst[31], icache_inst[19:12],
                    icache_inst[20], icache_inst[30:21], 1'b0};

    // ------------------------------------------------------------------
    // Handshake qualifiers
    // ------------------------------------------------------------------
    logic full;
    logic enq;
    logic deq;

    assign full        = (count_q == CW'(DEPTH));
    assign issue_valid = (count_q != '0);
    // No bypass: a full queue refuses the fetch even if the head leaves
    // in the same cycle, which costs one bubble but keeps fetch_req
    // independent of issue_ready.
    assign fetch_req   = (state_q == FETCH) && !full;
    // A redirect in flight (jalr or rollback) makes the current icache word
    // belong to a stale path, so it is dropped.
    assign enq = rdy && fetch_req && icache_hit && !rollback && !jalr_valid;
    assign deq = rdy && issue_valid && issue_ready && !rollback;

    always_comb begin
        next_pc_d = pc_q + 32'd4;
        if (is_branch && predict_taken) begin
            next_pc_d = pc_q + imm_b;
        end else if (is_jal) begin
            next_pc_d = pc_q + imm_j;
        end else if (is_jalr) begin
            // Target unknown until the ALU resolves it; hold pc.
            next_pc_d = pc_q;
        end
    end

    always_comb begin
        count_d = count_q;
        case ({enq, deq})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // ------------------------------------------------------------------
    // Fetch FSM, pc and queue pointers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (rdy) begin
            if (rollback) begin
                state_q <= FETCH;
                pc_q    <= rollback_pc;
                head_q  <= '0;
                tail_q  <= '0;
                count_q <= '0;
            end else begin
                if (jalr_valid) begin
                    // The ALU is authoritative even if we never stalled.
                    state_q <= FETCH;
                    pc_q    <= jalr_pc;
                end else if (enq) begin
                    pc_q <= next_pc_d;
                    if (is_jalr) begin
                        state_q <= JALR_WAIT;
                    end
                end
                if (enq) begin
                    tail_q <= tail_q + AW'(1);
                end
                if (deq) begin
                    head_q <= head_q + AW'(1);
                end
                count_q <= count_d;
            end
        end
    end

    // ------------------------------------------------------------------
    // Queue storage, one slot per generated block
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (rst) begin
                    inst_mem_q[gi] <= '0;
                    pc_mem_q[gi]   <= '0;
                    pred_mem_q[gi] <= 1'b0;
                end else if (enq && (tail_q == AW'(gi))) begin
                    inst_mem_q[gi] <= icache_inst;
                    pc_mem_q[gi]   <= pc_q;
                    pred_mem_q[gi] <= pred_d;
                end
            end
        end
    endgenerate

    assign issue_inst    = inst_mem_q[head_q];
    assign issue_pc      = pc_mem_q[head_q];
    assign issue_predict = pred_mem_q[head_q];

    assign pc_to_icache  = pc_q;
    assign predict_pc    = pc_q;
    assign q_count       = count_q;

endmodule

// File: tb/tb_ifetch_queue.sv
module tb_ifetch_queue;

    localparam logic [31:0] NOP  = 32'h0000_0013; // addi x0,x0,0
    localparam logic [31:0] BEQ  = 32'h0200_0063; // beq x0,x0,+0x20
    localparam logic [31:0] JAL  = 32'hFF9F_F06F; // jal x0,-8
    localparam logic [31:0] JALR = 32'h0000_8067; // jalr x0,0(x1)

    logic        clk;
    logic        rst;
    logic        rdy;
    logic [31:0] pc_to_icache;
    logic        fetch_req;
    logic        icache_hit;
    logic [31:0] icache_inst;
    logic [31:0] predict_pc;
    logic        predict_taken;
    logic        issue_valid;
    logic        issue_ready;
    logic [31:0] issue_inst;
    logic [31:0] issue_pc;
    logic        issue_predict;
    logic        jalr_valid;
    logic [31:0] jalr_pc;
    logic        rollback;
    logic [31:0] rollback_pc;
    logic [2:0]  q_count;

    int checks;
    int errors;

    ifetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk           (clk),
        .rst           (rst),
        .rdy           (rdy),
        .pc_to_icache  (pc_to_icache),
        .fetch_req     (fetch_req),
        .icache_hit    (icache_hit),
        .icache_inst   (icache_inst),
        .predict_pc    (predict_pc),
        .predict_taken (predict_taken),
        .issue_valid   (issue_valid),
        .issue_ready   (issue_ready),
        .issue_inst    (issue_inst),
        .issue_pc      (issue_pc),
        .issue_predict (issue_predict),
        .jalr_valid    (jalr_valid),
        .jalr_pc       (jalr_pc),
        .rollback      (rollback),
        .rollback_pc   (rollback_pc),
        .q_count       (q_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic show(input string what);
        $display("t=%0t %s pc=%08h cnt=%0d fr=%0b iv=%0b ipc=%08h ipred=%0b",
                 $time, what, pc_to_icache, q_count, fetch_req, issue_valid,
                 issue_pc, issue_predict);
    endtask

    task automatic do_rollback(input logic [31:0] target);
        rollback = 1'b1; rollback_pc = target; icache_hit = 1'b0;
        step();
        rollback = 1'b0;
        show("rollback");
    endtask

    initial begin
        checks = 0; errors = 0;
        rst = 1'b1; rdy = 1'b1; icache_hit = 1'b0; icache_inst = NOP;
        predict_taken = 1'b0; issue_ready = 1'b0; jalr_valid = 1'b0;
        jalr_pc = '0; rollback = 1'b0; rollback_pc = '0;
        step(); step();
        rst = 1'b0;
        show("reset");
        chk("rst_pc",      pc_to_icache,        32'h0);
        chk("rst_fetch",   32'(fetch_req),      32'd1);
        chk("rst_valid",   32'(issue_valid),    32'd0);
        chk("rst_count",   32'(q_count),        32'd0);
        chk("rst_pred",    32'(issue_predict),  32'd0);
        chk("rst_inst",    issue_inst,          32'h0);
        chk("rst_ipc",     issue_pc,            32'h0);
        chk("rst_ppc",     predict_pc,          32'h0);

        // ---- Fill the queue with addi, consumer not ready
        icache_hit = 1'b1; icache_inst = NOP;
        step(); show("enq0");
        chk("fill1_count", 32'(q_count),     32'd1);
        chk("fill1_valid", 32'(issue_valid), 32'd1);
        chk("fill1_ipc",   issue_pc,         32'h0);
        chk("fill1_inst",  issue_inst,       NOP);
        step(); step(); step(); show("full");
        chk("full_count",  32'(q_count),     32'd4);
        chk("full_pc",     pc_to_icache,     32'h10);
        chk("full_fetch",  32'(fetch_req),   32'd0);

        // ---- Full + dequeue + hit: dequeue only, one-cycle bubble
        issue_ready = 1'b1;
        step(); show("deq_full");
        chk("bub_count",   32'(q_count),     32'd3);
        chk("bub_pc",      pc_to_icache,     32'h10);
        chk("bub_ipc",     issue_pc,         32'h4);
        step(); show("enq_deq");
        chk("ed_count",    32'(q_count),     32'd3);
        chk("ed_pc",       pc_to_icache,     32'h14);
        chk("ed_ipc",      issue_pc,         32'h8);
        icache_hit = 1'b0;
        step(); show("drain");
        chk("dr1_ipc",     issue_pc,         32'hC);
        chk("dr1_count",   32'(q_count),     32'd2);
        step(); show("drain");
        chk("dr2_ipc",     issue_pc,         32'h10);
        step(); show("drain");
        chk("dr3_count",   32'(q_count),     32'd0);
        chk("dr3_valid",   32'(issue_valid), 32'd0);
        chk("dr3_pc",      pc_to_icache,     32'h14);
        issue_ready = 1'b0;

        // ---- Conditional branch, predicted taken / not taken
        do_rollback(32'h10);
        chk("rb10_pc",     pc_to_icache,     32'h10);
        icache_hit = 1'b1; icache_inst = BEQ; predict_taken = 1'b1;
        step(); show("beq_t");
        chk("beqt_pc",     pc_to_icache,     32'h30);
        chk("beqt_pred",   32'(issue_predict), 32'd1);
        chk("beqt_ipc",    issue_pc,         32'h10);
        chk("beqt_inst",   issue_inst,       BEQ);
        do_rollback(32'h10);
        chk("rb_count",    32'(q_count),     32'd0);
        icache_hit = 1'b1; icache_inst = BEQ; predict_taken = 1'b0;
        step(); show("beq_nt");
        chk("beqn_pc",     pc_to_icache,     32'h14);
        chk("beqn_pred",   32'(issue_predict), 32'd0);
        // Taken prediction on a non-branch must be ignored
        do_rollback(32'h50);
        icache_hit = 1'b1; icache_inst = NOP; predict_taken = 1'b1;
        step(); show("nop_t");
        chk("nopt_pc",     pc_to_icache,     32'h54);
        chk("nopt_pred",   32'(issue_predict), 32'd0);
        predict_taken = 1'b0;

        // ---- jal then jalr stall and resolution
        do_rollback(32'h40);
        icache_hit = 1'b1; icache_inst = JAL;
        step(); show("jal");
        chk("jal_pc",      pc_to_icache,     32'h38);
        icache_inst = JALR;
        step(); show("jalr");
        chk("jalr_pc_hold",  pc_to_icache,   32'h38);
        chk("jalr_count",    32'(q_count),   32'd2);
        chk("jalr_fetch",    32'(fetch_req), 32'd0);
        step(); show("stall");
        chk("stall_pc",      pc_to_icache,   32'h38);
        chk("stall_count",   32'(q_count),   32'd2);
        issue_ready = 1'b1;
        step(); show("stall_deq");
        issue_ready = 1'b0;
        chk("stall_deq_cnt", 32'(q_count),   32'd1);
        chk("stall_head_pc", issue_pc,       32'h38);
        chk("stall_head_in", issue_inst,     JALR);
        jalr_valid = 1'b1; jalr_pc = 32'h100;
        step(); show("jalr_res");
        jalr_valid = 1'b0; icache_inst = NOP;
        chk("res_pc",      pc_to_icache,     32'h100);
        chk("res_fetch",   32'(fetch_req),   32'd1);
        chk("res_count",   32'(q_count),     32'd1);
        step(); show("post_jalr");
        chk("pj_pc",       pc_to_icache,     32'h104);
        chk("pj_count",    32'(q_count),     32'd2);
        chk("pj_ipc",      issue_pc,         32'h38);

        // ---- Rollback beats simultaneous jalr_valid
        step(); show("fill3");
        chk("f3_count",    32'(q_count),     32'd3);
        rollback = 1'b1; rollback_pc = 32'h200; jalr_valid = 1'b1; jalr_pc = 32'h300;
        step(); show("rb_jalr");
        rollback = 1'b0; jalr_valid = 1'b0;
        chk("rbj_count",   32'(q_count),     32'd0);
        chk("rbj_valid",   32'(issue_valid), 32'd0);
        chk("rbj_pc",      pc_to_icache,     32'h200);
        chk("rbj_fetch",   32'(fetch_req),   32'd1);

        // ---- jalr_valid without stall still redirects, no enqueue
        jalr_valid = 1'b1; jalr_pc = 32'h300;
        step(); show("jalr_nostall");
        jalr_valid = 1'b0;
        chk("jns_pc",      pc_to_icache,     32'h300);
        chk("jns_count",   32'(q_count),     32'd0);

        // ---- rdy low mid-stream
        step(); show("stream");
        chk("s1_pc",       pc_to_icache,     32'h304);
        issue_ready = 1'b1;
        step(); show("stream");
        chk("s2_pc",       pc_to_icache,     32'h308);
        chk("s2_ipc",      issue_pc,         32'h304);
        rdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step(); show("rdy_low");
            chk("hold_pc",    pc_to_icache,  32'h308);
            chk("hold_count", 32'(q_count),  32'd1);
            chk("hold_ipc",   issue_pc,      32'h304);
        end
        rdy = 1'b1;
        step(); show("rdy_back");
        chk("rb_pc2",      pc_to_icache,     32'h30C);
        chk("rb_ipc2",     issue_pc,         32'h308);

        // ---- Reset takes effect with rdy low
        rdy = 1'b0; rst = 1'b1;
        step(); show("rst_rdy0");
        rst = 1'b0; rdy = 1'b1;
        chk("r0_pc",       pc_to_icache,     32'h0);
        chk("r0_count",    32'(q_count),     32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
